// File: rtl/ocp_pkg.sv
// Shared OCP 3.0 encodings and width defaults for the master-side request/response FSM.
package ocp_pkg;

    localparam int OCP_MDATA_WIDTH = 8;
    localparam int OCP_SDATA_WIDTH = 8;
    localparam int OCP_MADDR_WIDTH = 64;
    localparam int OCP_BLEN_WIDTH  = 10;

    typedef enum logic [2:0] {
        MCMD_IDLE = 3'b000,
        MCMD_WR   = 3'b001,
        MCMD_RD   = 3'b010,
        MCMD_RDEX = 3'b011,
        MCMD_RDL  = 3'b100,
        MCMD_WRNP = 3'b101,
        MCMD_WRC  = 3'b110,
        MCMD_BCST = 3'b111
    } mcmd_e;

    typedef enum logic [1:0] {
        SRESP_NULL = 2'b00,
        SRESP_DVA  = 2'b01,
        SRESP_FAIL = 2'b10,
        SRESP_ERR  = 2'b11
    } sresp_e;

endpackage

// File: rtl/ocp_master_fsm.sv
// OCP master: turns bridge write/read requests into held OCP request phases,
// returns DVA read data, and gates the OCP clock from sys_clk.
module ocp_master_fsm
    import ocp_pkg::*;
#(
    parameter int MDATA_WIDTH = OCP_MDATA_WIDTH,
    parameter int SDATA_WIDTH = OCP_SDATA_WIDTH,
    parameter int MADDR_WIDTH = OCP_MADDR_WIDTH
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic [MADDR_WIDTH-1:0] address,
    input  logic [9:0]             burst_length,
    input  logic [2:0]             burst_seq,
    input  logic                   read_request,
    input  logic                   write_request,
    input  logic [MDATA_WIDTH-1:0] write_data,
    output logic [MDATA_WIDTH-1:0] read_data,
    input  logic                   EnableClk,
    output logic                   Clk,
    input  logic                   SCmdAccept,
    input  logic [SDATA_WIDTH-1:0] SData,
    input  logic [1:0]             SResp,
    output logic [MADDR_WIDTH-1:0] MAddr,
    output logic [2:0]             MCmd,
    output logic [MDATA_WIDTH-1:0] MData,
    output logic [9:0]             MBurstLength,
    output logic                   MReqLast
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]             state,        state_nxt;
    logic [9:0]             beat_cnt,     beat_cnt_nxt;
    logic [2:0]             mcmd_nxt;
    logic [MADDR_WIDTH-1:0] maddr_nxt;
    logic [MDATA_WIDTH-1:0] mdata_nxt;
    logic [9:0]             mblen_nxt;
    logic                   mreqlast_nxt;
    logic [MDATA_WIDTH-1:0] read_data_nxt;
    // Sequence code is captured for debug only; every burst is incrementing with bridge-supplied addresses.
    logic [2:0]             unused_burst_seq, unused_burst_seq_nxt;
    logic [9:0]             wr_len;
    logic                   go_idle;

    assign Clk    = sys_clk & EnableClk;
    assign wr_len = (burst_length == 10'd0) ? 10'd1 : burst_length;

    always_comb begin
        // NOTE: every next value defaults to its current value so no branch leaves one unassigned (no latch).
        state_nxt            = state;
        beat_cnt_nxt         = beat_cnt;
        mcmd_nxt             = MCmd;
        maddr_nxt            = MAddr;
        mdata_nxt            = MData;
        mblen_nxt            = MBurstLength;
        mreqlast_nxt         = MReqLast;
        read_data_nxt        = read_data;
        unused_burst_seq_nxt = unused_burst_seq;
        go_idle              = 1'b0;

        case (state)
            ST_IDLE: begin
                go_idle = 1'b1;
                if (write_request) begin
                    go_idle              = 1'b0;
                    state_nxt            = ST_WR;
                    mcmd_nxt             = MCMD_WR;
                    maddr_nxt            = address;
                    mdata_nxt            = write_data;
                    mblen_nxt            = wr_len;
                    beat_cnt_nxt         = wr_len - 10'd1;
                    mreqlast_nxt         = (wr_len == 10'd1);
                    unused_burst_seq_nxt = burst_seq;
                end else if (read_request) begin
                    go_idle      = 1'b0;
                    state_nxt    = ST_RD;
                    mcmd_nxt     = MCMD_RD;
                    maddr_nxt    = address;
                    mblen_nxt    = 10'd1;
                    mreqlast_nxt = 1'b1;
                end
            end

            ST_WR: begin
                if (SCmdAccept) begin
                    if (beat_cnt != 10'd0) begin
                        // Bridge presents the next beat every cycle; write_request need not stay high.
                        maddr_nxt    = address;
                        mdata_nxt    = write_data;
                        beat_cnt_nxt = beat_cnt - 10'd1;
                        mreqlast_nxt = (beat_cnt == 10'd1);
                    end else begin
                        go_idle = 1'b1;
                    end
                end
            end

            ST_RD: begin
                if (SCmdAccept) begin
                    state_nxt    = ST_RESP;
                    mcmd_nxt     = MCMD_IDLE;
                    mreqlast_nxt = 1'b0;
                end
            end

            ST_RESP: begin
                case (SResp)
                    SRESP_DVA: begin
                        read_data_nxt = SData;
                        go_idle       = 1'b1;
                    end
                    SRESP_FAIL,
                    SRESP_ERR:  go_idle = 1'b1;
                    default:    ;
                endcase
            end

            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_nxt    = ST_IDLE;
            mcmd_nxt     = MCMD_IDLE;
            maddr_nxt    = '0;
            mdata_nxt    = '0;
            mblen_nxt    = 10'd0;
            mreqlast_nxt = 1'b0;
            beat_cnt_nxt = 10'd0;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            beat_cnt         <= 10'd0;
            MCmd             <= MCMD_IDLE;
            MAddr            <= '0;
            MData            <= '0;
            MBurstLength     <= 10'd0;
            MReqLast         <= 1'b0;
            read_data        <= '0;
            unused_burst_seq <= 3'd0;
        end else if (EnableClk) begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state            <= state_nxt;
            beat_cnt         <= beat_cnt_nxt;
            MCmd             <= mcmd_nxt;
            MAddr            <= maddr_nxt;
            MData            <= mdata_nxt;
            MBurstLength     <= mblen_nxt;
            MReqLast         <= mreqlast_nxt;
            read_data        <= read_data_nxt;
            unused_burst_seq <= unused_burst_seq_nxt;
        end
    end

endmodule

// File: tb/tb_ocp_master_fsm.sv
// Directed self-checking bench for ocp_master_fsm: writes, bursts, reads, error responses, clock gating, reset.
module tb_ocp_master_fsm;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic [63:0] address;
    logic [9:0]  burst_length;
    logic [2:0]  burst_seq;
    logic        read_request;
    logic        write_request;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        EnableClk;
    logic        Clk;
    logic        SCmdAccept;
    logic [7:0]  SData;
    logic [1:0]  SResp;
    logic [63:0] MAddr;
    logic [2:0]  MCmd;
    logic [7:0]  MData;
    logic [9:0]  MBurstLength;
    logic        MReqLast;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    ocp_master_fsm dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .address      (address),
        .burst_length (burst_length),
        .burst_seq    (burst_seq),
        .read_request (read_request),
        .write_request(write_request),
        .write_data   (write_data),
        .read_data    (read_data),
        .EnableClk    (EnableClk),
        .Clk          (Clk),
        .SCmdAccept   (SCmdAccept),
        .SData        (SData),
        .SResp        (SResp),
        .MAddr        (MAddr),
        .MCmd         (MCmd),
        .MData        (MData),
        .MBurstLength (MBurstLength),
        .MReqLast     (MReqLast)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".mcmd"},  64'(MCmd), 64'h0);
        check({tag, ".maddr"}, MAddr, 64'h0);
        check({tag, ".mdata"}, 64'(MData), 64'h0);
        check({tag, ".mblen"}, 64'(MBurstLength), 64'h0);
        check({tag, ".last"},  64'(MReqLast), 64'h0);
    endtask

    initial begin
        reset         = 1'b1;
        EnableClk     = 1'b1;
        address       = '0;
        burst_length  = '0;
        burst_seq     = 3'd0;
        read_request  = 1'b0;
        write_request = 1'b0;
        write_data    = '0;
        SCmdAccept    = 1'b0;
        SData         = '0;
        SResp         = 2'b00;

        #20 reset = 1'b0;

        // Reset state and clock gate follows sys_clk
        tick();
        check_idle("rst");
        check("rst.rdata", 64'(read_data), 64'h0);
        check("clk.high", 64'(Clk), 64'h1);
        @(negedge sys_clk); #1;
        check("clk.low", 64'(Clk), 64'h0);

        // Single write, accept delayed one cycle
        address = ONES; write_data = 8'hFF; burst_length = 10'd1; write_request = 1'b1;
        tick();
        check("wr1.mcmd", 64'(MCmd), 64'h1);
        check("wr1.maddr", MAddr, ONES);
        check("wr1.mdata", 64'(MData), 64'hFF);
        check("wr1.mblen", 64'(MBurstLength), 64'h1);
        check("wr1.last", 64'(MReqLast), 64'h1);
        write_request = 1'b0; address = '0; write_data = '0;
        tick();
        check("wr1.hold.mcmd", 64'(MCmd), 64'h1);
        check("wr1.hold.maddr", MAddr, ONES);
        check("wr1.hold.mdata", 64'(MData), 64'hFF);
        SCmdAccept = 1'b1;
        tick();
        check_idle("wr1.done");
        SCmdAccept = 1'b0;

        // Single read; DVA in the acceptance cycle must be ignored
        address = ONES; read_request = 1'b1;
        tick();
        check("rd1.mcmd", 64'(MCmd), 64'h2);
        check("rd1.maddr", MAddr, ONES);
        check("rd1.mblen", 64'(MBurstLength), 64'h1);
        check("rd1.last", 64'(MReqLast), 64'h1);
        read_request = 1'b0;
        tick();
        check("rd1.hold.mcmd", 64'(MCmd), 64'h2);
        SCmdAccept = 1'b1; SResp = 2'b01; SData = 8'h11;
        tick();
        check("rd1.acc.mcmd", 64'(MCmd), 64'h0);
        check("rd1.acc.last", 64'(MReqLast), 64'h0);
        check("rd1.acc.rdata", 64'(read_data), 64'h0);
        SCmdAccept = 1'b0; SResp = 2'b00; SData = 8'h22;
        tick();
        check("rd1.null.rdata", 64'(read_data), 64'h0);
        SResp = 2'b01; SData = 8'hFF;
        tick();
        check("rd1.dva.rdata", 64'(read_data), 64'hFF);
        check_idle("rd1.done");
        SResp = 2'b00;

        // Burst write of 4 beats with continuous accept
        SCmdAccept = 1'b1; burst_length = 10'd4; write_request = 1'b1;
        address = 64'h0; write_data = 8'h0;
        tick();
        check("bw.b0.mcmd", 64'(MCmd), 64'h1);
        check("bw.b0.maddr", MAddr, 64'h0);
        check("bw.b0.mdata", 64'(MData), 64'h0);
        check("bw.b0.mblen", 64'(MBurstLength), 64'h4);
        check("bw.b0.last", 64'(MReqLast), 64'h0);
        write_request = 1'b0; address = 64'h4; write_data = 8'h1;
        tick();
        check("bw.b1.maddr", MAddr, 64'h4);
        check("bw.b1.mdata", 64'(MData), 64'h1);
        check("bw.b1.last", 64'(MReqLast), 64'h0);
        address = 64'h8; write_data = 8'h2;
        tick();
        check("bw.b2.maddr", MAddr, 64'h8);
        check("bw.b2.mdata", 64'(MData), 64'h2);
        check("bw.b2.last", 64'(MReqLast), 64'h0);
        check("bw.b2.mblen", 64'(MBurstLength), 64'h4);
        address = 64'hC; write_data = 8'h3;
        tick();
        check("bw.b3.maddr", MAddr, 64'hC);
        check("bw.b3.mdata", 64'(MData), 64'h3);
        check("bw.b3.last", 64'(MReqLast), 64'h1);
        check("bw.b3.mblen", 64'(MBurstLength), 64'h4);
        check("bw.b3.mcmd", 64'(MCmd), 64'h1);
        address = '0; write_data = '0;
        tick();
        check_idle("bw.done");

        // Read with ERR response keeps previous read_data
        address = 64'h1234; read_request = 1'b1;
        tick();
        check("err.mcmd", 64'(MCmd), 64'h2);
        read_request = 1'b0;
        tick();
        check("err.acc.mcmd", 64'(MCmd), 64'h0);
        SCmdAccept = 1'b0; SResp = 2'b11; SData = 8'h00;
        tick();
        check("err.rdata", 64'(read_data), 64'hFF);
        check_idle("err.done");
        SResp = 2'b00;

        // Read with FAIL response behaves the same
        read_request = 1'b1; address = 64'h5678;
        tick();
        check("fail.mcmd", 64'(MCmd), 64'h2);
        check("fail.maddr", MAddr, 64'h5678);
        read_request = 1'b0; SCmdAccept = 1'b1;
        tick();
        SCmdAccept = 1'b0; SResp = 2'b10; SData = 8'h55;
        tick();
        check("fail.rdata", 64'(read_data), 64'hFF);
        check_idle("fail.done");
        SResp = 2'b00;

        // Both requests with burst_length 0: write wins, length becomes 1
        write_request = 1'b1; read_request = 1'b1; burst_length = 10'd0;
        address = 64'hAB; write_data = 8'h5A;
        tick();
        check("prio.mcmd", 64'(MCmd), 64'h1);
        check("prio.mblen", 64'(MBurstLength), 64'h1);
        check("prio.last", 64'(MReqLast), 64'h1);
        check("prio.mdata", 64'(MData), 64'h5A);
        write_request = 1'b0; read_request = 1'b0; SCmdAccept = 1'b1;
        tick();
        check_idle("prio.done");
        SCmdAccept = 1'b0;

        // EnableClk low freezes a pending write and gates Clk
        burst_length = 10'd2; write_request = 1'b1; address = 64'h10; write_data = 8'hA0;
        tick();
        check("en.b0.maddr", MAddr, 64'h10);
        write_request = 1'b0; EnableClk = 1'b0; SCmdAccept = 1'b1;
        address = 64'h14; write_data = 8'hA1;
        tick();
        check("en.frz.clk", 64'(Clk), 64'h0);
        check("en.frz.mcmd", 64'(MCmd), 64'h1);
        check("en.frz.maddr", MAddr, 64'h10);
        check("en.frz.mdata", 64'(MData), 64'hA0);
        check("en.frz.last", 64'(MReqLast), 64'h0);
        tick();
        check("en.frz2.maddr", MAddr, 64'h10);
        EnableClk = 1'b1;
        tick();
        check("en.b1.maddr", MAddr, 64'h14);
        check("en.b1.mdata", 64'(MData), 64'hA1);
        check("en.b1.last", 64'(MReqLast), 64'h1);
        tick();
        check_idle("en.done");

        // Reset asserted mid-burst after the third beat
        burst_length = 10'd4; write_request = 1'b1; address = 64'h0; write_data = 8'h10;
        tick();
        write_request = 1'b0; address = 64'h4; write_data = 8'h11;
        tick();
        address = 64'h8; write_data = 8'h12;
        tick();
        check("mrst.pre.maddr", MAddr, 64'h8);
        check("mrst.pre.mdata", 64'(MData), 64'h12);
        #1 reset = 1'b1;
        #1;
        check_idle("mrst");
        check("mrst.rdata", 64'(read_data), 64'h0);
        SCmdAccept = 1'b0; address = '0; write_data = '0;
        @(negedge sys_clk);
        reset = 1'b0;
        tick();
        check_idle("mrst.after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
